// File: rtl/spi_mnrch16.sv
// spi_mnrch16 -- SPI monarch, one 16-bit full-duplex transaction per wrt pulse.
// SPI mode 3 (SCLK idles high, data launched on fall, sampled on rise), MSB first.
// SCLK is the MSB of a divider that only counts while a transaction is in flight.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   wrt      1-clk start pulse; ignored while a transaction is in progress
//   wt_data  16-bit word shifted out on MOSI, bit 15 first
//   MISO     serial data from the serf
//   SS_n     active-low serf select
//   SCLK     serial clock, idles high
//   MOSI     serial data to the serf
//   done     transaction complete; held until the next accepted wrt
//   rd_data  word received from MISO, valid while done=1
module spi_mnrch16 #(
    parameter int unsigned DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] wt_data,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        done,
    output logic [15:0] rd_data
);

    localparam logic IDLE  = 1'b0;
    localparam logic SHIFT = 1'b1;

    // Preset 10_1..1 gives a front porch of 2^(DIV_W-2)+1 clk before the
    // first SCLK fall; that fall is not a shift point (smpl_seen still 0).
    localparam logic [DIV_W-1:0] DIV_PRESET = {2'b10, {(DIV_W-2){1'b1}}};
    localparam logic [DIV_W-1:0] DIV_RISE   = {1'b0, {(DIV_W-1){1'b1}}};

    logic             state;
    logic [DIV_W-1:0] sclk_div;
    logic [15:0]      shft_reg;
    logic             smpl;
    logic             smpl_seen;
    logic [3:0]       cnt;
    logic             rise_imm;
    logic             fall_imm;

    // Decoded one clk ahead of the SCLK edge they announce.
    assign rise_imm = (sclk_div == DIV_RISE);
    assign fall_imm = &sclk_div;

    assign SCLK    = sclk_div[DIV_W-1];
    assign MOSI    = shft_reg[15];
    assign rd_data = shft_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sclk_div  <= '1;
            shft_reg  <= '0;
            smpl      <= 1'b0;
            smpl_seen <= 1'b0;
            cnt       <= '0;
            SS_n      <= 1'b1;
            done      <= 1'b0;
        end else if (state == IDLE) begin
            sclk_div <= '1;
            if (wrt) begin
                shft_reg  <= wt_data;
                sclk_div  <= DIV_PRESET;
                SS_n      <= 1'b0;
                done      <= 1'b0;
                smpl_seen <= 1'b0;
                cnt       <= '0;
                state     <= SHIFT;
            end
        end else begin
            if (rise_imm) begin
                smpl      <= MISO;
                smpl_seen <= 1'b1;
            end
            if (fall_imm && smpl_seen) begin
                shft_reg <= {shft_reg[14:0], smpl};
                cnt      <= cnt + 4'd1;
                if (cnt == 4'd15) begin
                    // Last shift: freeze the divider at all ones so SCLK
                    // stays high through the back porch and into idle.
                    SS_n  <= 1'b1;
                    done  <= 1'b1;
                    state <= IDLE;
                end else begin
                    sclk_div <= sclk_div + 1'b1;
                end
            end else begin
                sclk_div <= sclk_div + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_mnrch16.sv
`timescale 1ns/1ps
// tb_spi_mnrch16 -- directed bench for spi_mnrch16 with a small iNEMO-like
// serf model (write regs, WHO_AM_I=0x6A, 0xA5 filler on writes) and a
// MOSI->MISO loopback mode.
module tb_spi_mnrch16;

    logic        clk;
    logic        rst;
    logic        wrt;
    logic [15:0] wt_data;
    logic        MISO;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        done;
    logic [15:0] rd_data;

    int total = 0;
    int bad   = 0;

    logic loopback = 1'b0;

    spi_mnrch16 #(.DIV_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt),
        .wt_data (wt_data),
        .MISO    (MISO),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .done    (done),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- serf model ----------------
    logic [15:0] s_word = 16'h0000;
    logic [3:0]  s_idx  = 4'd15;
    logic [15:0] s_rx   = 16'h0000;
    int          s_rise = 0;
    logic        ss_q   = 1'b1;
    logic        sclk_q = 1'b1;
    logic [7:0]  serf_regs [0:127];
    logic        serf_miso;

    assign serf_miso = s_word[s_idx];
    assign MISO = loopback ? MOSI : serf_miso;

    always @(SS_n or SCLK) begin
        if (ss_q && !SS_n) begin
            s_word = 16'h00A5;
            s_idx  = 4'd15;
            s_rx   = 16'h0000;
            s_rise = 0;
        end else if (!SS_n && !sclk_q && SCLK) begin
            s_rx   = {s_rx[14:0], MOSI};
            s_rise = s_rise + 1;
            if (s_rise == 8 && s_rx[7])
                s_word[7:0] = (s_rx[6:0] == 7'h0F) ? 8'h6A : serf_regs[s_rx[6:0]];
            if (s_rise == 16 && !s_rx[15])
                serf_regs[s_rx[14:8]] = s_rx[7:0];
        end else if (!SS_n && sclk_q && !SCLK && s_rise > 0 && s_idx > 0) begin
            s_idx = s_idx - 4'd1;
        end
        ss_q   = SS_n;
        sclk_q = SCLK;
    end

    // ---------------- bus monitor ----------------
    logic m_ss = 1'b1;
    logic m_sclk = 1'b1;
    logic first_fall_pending = 1'b0;
    time  t_ssfall = 0;
    time  t_ssrise = 0;
    time  t_first_fall = 0;
    time  t_last_rise = 0;
    int   rise_cnt = 0;

    always @(SS_n or SCLK) begin
        if (m_ss === 1'b1 && SS_n === 1'b0) begin
            t_ssfall = $time;
            first_fall_pending = 1'b1;
        end
        if (m_ss === 1'b0 && SS_n === 1'b1)
            t_ssrise = $time;
        if (SS_n === 1'b0 && m_sclk === 1'b1 && SCLK === 1'b0 && first_fall_pending) begin
            t_first_fall = $time;
            first_fall_pending = 1'b0;
        end
        if (SS_n === 1'b0 && m_sclk === 1'b0 && SCLK === 1'b1) begin
            rise_cnt = rise_cnt + 1;
            t_last_rise = $time;
        end
        m_ss   = SS_n;
        m_sclk = SCLK;
    end

    int done_rises = 0;
    always @(posedge done) done_rises = done_rises + 1;

    int sclk_viol = 0;
    always @(negedge clk) if (SS_n === 1'b1 && SCLK !== 1'b1) sclk_viol = sclk_viol + 1;

    // ---------------- helpers (stimulus only) ----------------
    task automatic start_xfer(input logic [15:0] d);
        @(negedge clk);
        wrt = 1'b1;
        wt_data = d;
        @(negedge clk);
        wrt = 1'b0;
    endtask

    // Counts clk edges after the call point until done is seen (-1 on timeout).
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 2000; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        int dev;
        rst = 1'b1;
        wrt = 1'b0;
        wt_data = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++; if (SS_n !== 1'b1) begin bad++; $display("FAIL reset_ss_n got=%b want=1", SS_n); end
        total++; if (SCLK !== 1'b1) begin bad++; $display("FAIL reset_sclk got=%b want=1", SCLK); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (rd_data !== 16'h0000) begin bad++; $display("FAIL reset_rd_data got=%h want=0000", rd_data); end
        total++; if (MOSI !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b want=0", MOSI); end
        dev = 0;
        repeat (100) begin
            @(negedge clk);
            if (SS_n !== 1'b1 || SCLK !== 1'b1 || done !== 1'b0 || rd_data !== 16'h0000) dev++;
        end
        total++; if (dev !== 0) begin bad++; $display("FAIL reset_stable deviating_cycles=%0d want=0", dev); end
    endtask

    task automatic test_write_reg;
        int lat;
        loopback = 1'b0;
        start_xfer(16'h0D02);
        total++; if (SS_n !== 1'b0) begin bad++; $display("FAIL wr_ss_active got=%b want=0", SS_n); end
        wait_done(lat);
        total++; if (lat !== 521) begin bad++; $display("FAIL wr_latency got=%0d want=521", lat); end
        total++; if (serf_regs[13] !== 8'h02) begin bad++; $display("FAIL wr_serf_reg0D got=%h want=02", serf_regs[13]); end
        total++; if (rd_data !== 16'h00A5) begin bad++; $display("FAIL wr_rd_data got=%h want=00a5", rd_data); end
        total++; if (SS_n !== 1'b1 || SCLK !== 1'b1) begin bad++; $display("FAIL wr_idle_lines ss_n=%b sclk=%b want=1,1", SS_n, SCLK); end
    endtask

    task automatic test_whoami;
        int lat;
        loopback = 1'b0;
        start_xfer(16'h8F00);
        wait_done(lat);
        total++; if (lat !== 521) begin bad++; $display("FAIL whoami_latency got=%0d want=521", lat); end
        total++; if (rd_data !== 16'h006A) begin bad++; $display("FAIL whoami_rd_data got=%h want=006a", rd_data); end
    endtask

    task automatic test_loopback;
        int lat;
        int r0;
        int v0;
        loopback = 1'b1;
        r0 = rise_cnt;
        v0 = sclk_viol;
        start_xfer(16'hA5C3);
        wait_done(lat);
        repeat (5) @(negedge clk);
        total++; if (rd_data !== 16'hA5C3) begin bad++; $display("FAIL loop_rd_data got=%h want=a5c3", rd_data); end
        total++; if (rise_cnt - r0 !== 16) begin bad++; $display("FAIL loop_sclk_rises got=%0d want=16", rise_cnt - r0); end
        total++; if ((t_first_fall - t_ssfall) / 10 !== 9) begin bad++; $display("FAIL loop_front_porch got=%0d want=9", (t_first_fall - t_ssfall) / 10); end
        total++; if ((t_ssrise - t_last_rise) / 10 !== 16) begin bad++; $display("FAIL loop_back_porch got=%0d want=16", (t_ssrise - t_last_rise) / 10); end
        total++; if (sclk_viol - v0 !== 0) begin bad++; $display("FAIL loop_sclk_idle_high low_cycles=%0d want=0", sclk_viol - v0); end
        loopback = 1'b0;
    endtask

    task automatic test_wrt_while_busy;
        int lat;
        int d0;
        loopback = 1'b1;
        d0 = done_rises;
        start_xfer(16'h3C5A);
        repeat (99) @(negedge clk);
        wrt = 1'b1;
        wt_data = 16'hFFFF;
        @(negedge clk);
        wrt = 1'b0;
        wait_done(lat);
        total++; if (lat + 100 !== 521) begin bad++; $display("FAIL busy_latency got=%0d want=521", lat + 100); end
        total++; if (rd_data !== 16'h3C5A) begin bad++; $display("FAIL busy_rd_data got=%h want=3c5a", rd_data); end
        repeat (600) @(negedge clk);
        total++; if (done_rises - d0 !== 1) begin bad++; $display("FAIL busy_done_count got=%0d want=1", done_rises - d0); end
        total++; if (done !== 1'b1 || SS_n !== 1'b1) begin bad++; $display("FAIL busy_idle done=%b ss_n=%b want=1,1", done, SS_n); end
        loopback = 1'b0;
    endtask

    task automatic test_back_to_back;
        int lat;
        int d0;
        int dev;
        loopback = 1'b1;
        d0 = done_rises;
        start_xfer(16'h1234);
        repeat (520) @(negedge clk);
        // wrt high exactly on the edge where done rises
        wrt = 1'b1;
        wt_data = 16'hFFFF;
        @(negedge clk);
        wrt = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done_edge got=%b want=1", done); end
        total++; if (rd_data !== 16'h1234) begin bad++; $display("FAIL b2b_rd_data got=%h want=1234", rd_data); end
        dev = 0;
        repeat (40) begin
            @(negedge clk);
            if (SS_n !== 1'b1 || done !== 1'b1 || rd_data !== 16'h1234) dev++;
        end
        total++; if (dev !== 0) begin bad++; $display("FAIL b2b_wrt_ignored deviating_cycles=%0d want=0", dev); end
        total++; if (done_rises - d0 !== 1) begin bad++; $display("FAIL b2b_done_count got=%0d want=1", done_rises - d0); end
        // new transaction from IDLE with done=1: done drops one clk later
        start_xfer(16'h5A5A);
        total++; if (done !== 1'b0 || SS_n !== 1'b0) begin bad++; $display("FAIL b2b_restart done=%b ss_n=%b want=0,0", done, SS_n); end
        wait_done(lat);
        total++; if (lat !== 521) begin bad++; $display("FAIL b2b_latency got=%0d want=521", lat); end
        total++; if (rd_data !== 16'h5A5A) begin bad++; $display("FAIL b2b_rd_data2 got=%h want=5a5a", rd_data); end
        loopback = 1'b0;
    endtask

    task automatic test_reset_mid;
        int lat;
        loopback = 1'b0;
        start_xfer(16'h8F00);
        repeat (299) @(negedge clk);
        total++; if (SS_n !== 1'b0) begin bad++; $display("FAIL mid_busy ss_n=%b want=0", SS_n); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (SS_n !== 1'b1 || SCLK !== 1'b1) begin bad++; $display("FAIL mid_rst_lines ss_n=%b sclk=%b want=1,1", SS_n, SCLK); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_rst_done got=%b want=0", done); end
        total++; if (rd_data !== 16'h0000) begin bad++; $display("FAIL mid_rst_rd_data got=%h want=0000", rd_data); end
        repeat (10) @(negedge clk);
        start_xfer(16'h8F00);
        wait_done(lat);
        total++; if (lat !== 521) begin bad++; $display("FAIL mid_after_latency got=%0d want=521", lat); end
        total++; if (rd_data !== 16'h006A) begin bad++; $display("FAIL mid_after_rd_data got=%h want=006a", rd_data); end
    endtask

    initial begin
        rst = 1'b1;
        wrt = 1'b0;
        wt_data = 16'h0000;
        test_reset();
        test_write_reg();
        test_whoami();
        test_loopback();
        test_wrt_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
